// File: rtl/acc_feeder.sv
// acc_feeder: host-word FIFO that hands whole frames to the accelerator wrapper via the drdy handshake.
// Optional busy timeout in WAIT is compiled in with `define ACC_FEEDER_TMO_EN.
module acc_feeder #(
    parameter int W     = 8,
    parameter int FRAME = 8,
    parameter int DEPTH = 16,
    parameter int TMO   = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         free,
    input  logic         dacc,
    output logic         drdy,
    output logic [W-1:0] dout,
    output logic         busy,
    output logic [7:0]   frames,
    output logic         err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(FRAME) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_GAP,
        S_GO,
        S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WCW-1:0] wc_q, wc_d;
    logic [7:0]     frames_q, frames_d;
    logic           drdy_q, drdy_d;
    logic           busy_q, busy_d;
    logic           push, pop;

`ifdef ACC_FEEDER_TMO_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
`endif

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_XFER) && dacc;

    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        frames_d = frames_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
`ifdef ACC_FEEDER_TMO_EN
        tmo_d = tmo_q;
        err_d = err_q;
`endif
        case (state_q)
            S_IDLE: if (count_q >= CW'(FRAME) && free) state_d = S_REQ;
            S_REQ: begin
                state_d = S_XFER;
                wc_d    = '0;
            end
            S_XFER: begin
                if (dacc) begin
                    if (wc_q == WCW'(FRAME - 1)) state_d = S_GAP;
                    else wc_d = wc_q + WCW'(1);
                end
            end
            S_GAP: state_d = S_GO;
            S_GO: begin
                state_d  = S_WAIT;
                frames_d = frames_q + 8'd1;
`ifdef ACC_FEEDER_TMO_EN
                tmo_d = '0;
`endif
            end
            S_WAIT: begin
                if (free) begin
                    state_d = S_IDLE;
`ifdef ACC_FEEDER_TMO_EN
                end else if (tmo_q == TW'(TMO - 1)) begin
                    // TMO-th consecutive cycle of free=0 in WAIT gives up on the wrapper
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        drdy_d = (state_d == S_REQ) || (state_d == S_XFER) || (state_d == S_GO);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wc_q     <= '0;
            frames_q <= '0;
            drdy_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ACC_FEEDER_TMO_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wc_q     <= wc_d;
            frames_q <= frames_d;
            drdy_q   <= drdy_d;
            busy_q   <= busy_d;
`ifdef ACC_FEEDER_TMO_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign drdy   = drdy_q;
    assign busy   = busy_q;
    assign frames = frames_q;
    assign dout   = (state_q == S_XFER) ? mem_q[rd_ptr_q] : '0;

`ifdef ACC_FEEDER_TMO_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_feeder.sv
// Self-checking bench for acc_feeder: queue-based FIFO model plus a directed wrapper handshake.
module tb_acc_feeder;

    localparam int W     = 8;
    localparam int FRAME = 8;
    localparam int DEPTH = 16;
    localparam int TMO   = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         free;
    logic         dacc;
    logic         drdy;
    logic [W-1:0] dout;
    logic         busy;
    logic [7:0]   frames;
    logic         err;

    always #5 clk = ~clk;

    acc_feeder #(.W(W), .FRAME(FRAME), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .free(free), .dacc(dacc), .drdy(drdy), .dout(dout), .busy(busy),
        .frames(frames), .err(err)
    );

    int           errors = 0;
    int           checks = 0;
    int           exp_frames = 0;
    logic [W-1:0] mq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cycle(input bit v, input logic [W-1:0] d);
        bit acc;
        in_valid = v;
        in_data  = d;
        chk("in_ready", in_ready, mq.size() != DEPTH);
        acc = v && (mq.size() != DEPTH);
        tick();
        if (acc) mq.push_back(d);
        in_valid = 1'b0;
    endtask

    // Plays the wrapper: free until REQ, load one cycle, accept FRAME words, then GAP/GO/WAIT.
    task automatic run_frame(input int stall_at, input int stall_len, input bit rnd_push,
                             input bit hold_wait, output int lat);
        int           n, guard, stalled;
        bit           acc;
        logic [W-1:0] d;
        free = 1'b1;
        dacc = 1'b0;
        lat  = 0;
        while (!drdy && lat < 4) begin
            tick();
            lat++;
        end
        if (!drdy) begin
            chk("req_timeout", drdy, 1);
            free = 1'b0;
            return;
        end
        chk("req_dout", dout, 0);
        chk("req_busy", busy, 1);
        free = 1'b0;
        tick();
        chk("xfer1_drdy", drdy, 1);
        n = 0; stalled = 0; guard = 0;
        while (n < FRAME && guard < FRAME + stall_len + 8) begin
            guard++;
            if (n == stall_at && stalled < stall_len) begin
                dacc = 1'b0;
                stalled++;
            end else begin
                dacc = 1'b1;
            end
            chk("xfer_drdy", drdy, 1);
            chk("xfer_dout", dout, mq[0]);
            acc = 1'b0;
            d   = '0;
            if (rnd_push) begin
                d        = W'($urandom);
                in_valid = 1'($urandom_range(0, 1));
                in_data  = d;
                chk("xfer_in_ready", in_ready, mq.size() != DEPTH);
                acc = in_valid && (mq.size() != DEPTH);
            end
            tick();
            if (dacc) begin
                void'(mq.pop_front());
                n++;
            end
            if (acc) mq.push_back(d);
        end
        in_valid = 1'b0;
        chk("xfer_pops", n, FRAME);
        chk("gap_drdy", drdy, 0);
        chk("gap_dout", dout, 0);
        dacc = 1'b1;
        tick();
        dacc = 1'b0;
        chk("go_drdy", drdy, 1);
        tick();
        exp_frames = (exp_frames + 1) % 256;
        chk("wait_drdy", drdy, 0);
        chk("wait_busy", busy, 1);
        chk("frames", frames, exp_frames);
        if (hold_wait) return;
        tick();
        chk("wait_hold_busy", busy, 1);
        free = 1'b1;
        tick();
        free = 1'b0;
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int lat, k, nw, g;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; free = 1'b0; dacc = 1'b0;
        tick();
        tick();
        chk("rst_drdy", drdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_frames", frames, 0);
        chk("rst_err", err, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;
        tick();

        // Partial then single frame 0x01..0x08
        free = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            push_cycle(1'b1, W'(i));
            chk("partial_drdy", drdy, 0);
            chk("partial_busy", busy, 0);
        end
        push_cycle(1'b1, W'(8));
        chk("eighth_drdy", drdy, 0);
        run_frame(FRAME + 1, 0, 1'b0, 1'b0, lat);
        chk("req_latency", lat, 1);
        chk("empty_in_ready", in_ready, 1);

        // Overfill with wrapper busy, then two frames, the first with a dacc stall after the 3rd pop
        free = 1'b0;
        for (int i = 0; i < 17; i++) push_cycle(1'b1, W'($urandom));
        chk("full_in_ready", in_ready, 0);
        run_frame(3, 5, 1'b0, 1'b0, lat);
        run_frame(FRAME + 1, 0, 1'b0, 1'b0, lat);
        chk("drained_in_ready", in_ready, 1);
        chk("frames_after_full", frames, 3);

        // Randomized pushes, stalls and concurrent push/pop
        for (int it = 0; it < 6; it++) begin
            nw = $urandom_range(0, 12);
            for (int j = 0; j < nw; j++) push_cycle(1'($urandom_range(0, 1)), W'($urandom));
            g = 0;
            while (mq.size() >= FRAME && g < 4) begin
                run_frame($urandom_range(0, FRAME), $urandom_range(0, 3), 1'b1, 1'b0, lat);
                g++;
            end
        end

        // WAIT with free held low
        while (mq.size() < FRAME) push_cycle(1'b1, W'($urandom));
        run_frame(FRAME + 1, 0, 1'b0, 1'b1, lat);
`ifdef ACC_FEEDER_TMO_EN
        k = 0;
        while (!err && k < 60) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, TMO);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_drdy", drdy, 0);
        tick();
        chk("tmo_err_sticky", err, 1);
`else
        for (int i = 0; i < 30; i++) tick();
        chk("notmo_err", err, 0);
        chk("notmo_busy", busy, 1);
        free = 1'b1;
        tick();
        free = 1'b0;
        chk("notmo_idle_busy", busy, 0);
`endif

        // Reset in the middle of XFER discards buffered words
        while (mq.size() < FRAME) push_cycle(1'b1, W'($urandom));
        free = 1'b1;
        k = 0;
        while (!drdy && k < 4) begin
            tick();
            k++;
        end
        chk("midrst_req", drdy, 1);
        free = 1'b0;
        tick();
        dacc = 1'b1;
        tick();
        tick();
        rst  = 1'b1;
        dacc = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_drdy", drdy, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_frames", frames, 0);
        chk("midrst_err", err, 0);
        chk("midrst_dout", dout, 0);
        mq.delete();
        exp_frames = 0;
        free = 1'b1;
        tick();
        tick();
        tick();
        chk("midrst_empty_drdy", drdy, 0);
        chk("midrst_empty_busy", busy, 0);
        free = 1'b0;
        for (int i = 0; i < FRAME; i++) push_cycle(1'b1, W'($urandom));
        run_frame(2, 2, 1'b0, 1'b0, lat);
        chk("post_rst_frames", frames, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
